// File: rtl/matriz_pkg.sv
// Shared types and helpers for the Bareiss determinant engine.
// Holds the state encoding, the bus element index and the accumulator width rule.
package matriz_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PIVOT,
      S_SEARCH,
      S_SWAP,
      S_UPDATE,
      S_FINISH
   } det_state_t;

   function automatic int idx(input int i, input int j, input int n_max);
      return i * n_max + j;
   endfunction

   // Wide enough for every Bareiss intermediate of an n_max x n_max w-bit matrix.
   function automatic int calc_iw(input int n_max, input int w);
      return n_max * (w + 2) + 2;
   endfunction

endpackage

// File: rtl/matriz_determ_nxn_if.sv
// Start/done command bus between the coprocessor decoder and the determinant engine.
interface matriz_determ_nxn_if #(
   parameter int N_MAX = 5,
   parameter int W     = 8,
   parameter int OW    = 32
);
   logic                      start;
   logic [3:0]                n_sel;
   logic [N_MAX*N_MAX*W-1:0]  matriz_A;
   logic                      busy;
   logic                      done;
   logic signed [OW-1:0]      det;
   logic                      ovf;
   logic                      err;

   modport master (
      output start, n_sel, matriz_A,
      input  busy, done, det, ovf, err
   );

   modport slave (
      input  start, n_sel, matriz_A,
      output busy, done, det, ovf, err
   );
endinterface

// File: rtl/det_bareiss_pe.sv
// One Bareiss element step: (a*piv - ik*kj) / prev, plus an exactness flag.
module det_bareiss_pe #(
   parameter int IW = 52
) (
   input  logic signed [IW-1:0] a,
   input  logic signed [IW-1:0] piv,
   input  logic signed [IW-1:0] ik,
   input  logic signed [IW-1:0] kj,
   input  logic signed [IW-1:0] prev,
   output logic signed [IW-1:0] q,
   output logic                 exact
);
   localparam int PW = 2 * IW;

   logic signed [PW-1:0] num;
   logic signed [PW-1:0] den;
   logic signed [PW-1:0] quo;
   logic signed [PW-1:0] rem;

   always_comb begin
      num   = PW'(a) * PW'(piv) - PW'(ik) * PW'(kj);
      den   = PW'(prev);
      quo   = '0;
      rem   = '0;
      if (den != '0) begin
         quo = num / den;
         rem = num % den;
      end
      q     = quo[IW-1:0];
      exact = (rem == '0);
   end
endmodule

// File: rtl/matriz_determ_nxn.sv
// Sequential n x n determinant via fraction-free elimination with pivot row swaps.
// Define DET_SAT_EN to saturate det on overflow instead of wrapping.
module matriz_determ_nxn
   import matriz_pkg::*;
#(
   parameter int N_MAX = 5,
   parameter int W     = 8,
   parameter int OW    = 32
) (
   input logic          clk,
   input logic          rst,
   matriz_determ_nxn_if.slave bus
);
   localparam int IW  = calc_iw(N_MAX, W);
   localparam int IXW = $clog2(N_MAX);
   localparam int XW  = (IW > OW) ? IW : OW;

   typedef logic signed [IW-1:0] elem_t;
   typedef logic [IXW-1:0]       ix_t;

   det_state_t state, state_nx;

   elem_t m [N_MAX][N_MAX];
   elem_t prev;
   elem_t pe_q;
   elem_t res;
   logic  pe_exact;

   logic [3:0] n_r;
   ix_t        n_m1, k, i, j, r, k1;
   logic       neg, zero, n_ok;

   logic signed [XW-1:0] rx;
   logic                 rx_ovf;
   logic [OW-1:0]        det_nx;

   det_bareiss_pe #(.IW(IW)) u_pe (
      .a     (m[i][j]),
      .piv   (m[k][k]),
      .ik    (m[i][k]),
      .kj    (m[k][j]),
      .prev  (prev),
      .q     (pe_q),
      .exact (pe_exact)
   );

   assign k1   = k + ix_t'(1);
   assign n_ok = (n_r != 4'd0) && (n_r <= 4'(N_MAX));

   always_comb begin
      res = '0;
      if (!zero) res = neg ? -m[n_m1][n_m1] : m[n_m1][n_m1];
   end

   assign rx     = XW'(res);
   assign rx_ovf = !((&rx[XW-1:OW-1]) || !(|rx[XW-1:OW-1]));

`ifdef DET_SAT_EN
   assign det_nx = !rx_ovf ? rx[OW-1:0] :
                   rx[XW-1] ? {1'b1, {(OW-1){1'b0}}} :
                              {1'b0, {(OW-1){1'b1}}};
`else
   assign det_nx = rx[OW-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (bus.start) state_nx = S_LOAD;
         S_LOAD:   state_nx = (!n_ok || n_m1 == '0) ? S_FINISH : S_PIVOT;
         S_PIVOT:  state_nx = (m[k][k] != '0) ? S_UPDATE : S_SEARCH;
         S_SEARCH: begin
            if (m[r][k] != '0)   state_nx = S_SWAP;
            else if (r == n_m1)  state_nx = S_FINISH;
         end
         S_SWAP:   state_nx = S_UPDATE;
         S_UPDATE: begin
            if (i == n_m1 && j == n_m1)
               state_nx = (k1 == n_m1) ? S_FINISH : S_PIVOT;
         end
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.det  <= '0;
         bus.ovf  <= 1'b0;
         bus.err  <= 1'b0;
         prev     <= elem_t'(1);
         neg      <= 1'b0;
         zero     <= 1'b0;
         n_r      <= '0;
         n_m1     <= '0;
         k        <= '0;
         i        <= '0;
         j        <= '0;
         r        <= '0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  bus.busy <= 1'b1;
                  bus.det  <= '0;
                  bus.ovf  <= 1'b0;
                  bus.err  <= 1'b0;
                  n_r      <= bus.n_sel;
                  n_m1     <= ix_t'(bus.n_sel - 4'd1);
                  for (int a = 0; a < N_MAX; a++)
                     for (int b = 0; b < N_MAX; b++)
                        m[ix_t'(a)][ix_t'(b)] <= elem_t'($signed(
                           bus.matriz_A[idx(a, b, N_MAX)*W +: W]));
               end
            end
            S_LOAD: begin
               prev <= elem_t'(1);
               neg  <= 1'b0;
               k    <= '0;
               zero <= !n_ok;
            end
            S_PIVOT: begin
               i <= k1;
               j <= k1;
               r <= k1;
            end
            S_SEARCH: begin
               if (m[r][k] == '0) begin
                  if (r == n_m1) zero <= 1'b1;
                  else           r <= r + ix_t'(1);
               end
            end
            S_SWAP: begin
               for (int c = 0; c < N_MAX; c++) begin
                  m[k][ix_t'(c)] <= m[r][ix_t'(c)];
                  m[r][ix_t'(c)] <= m[k][ix_t'(c)];
               end
               neg <= !neg;
            end
            S_UPDATE: begin
               assert (pe_exact);
               m[i][j] <= pe_q;
               if (j == n_m1) begin
                  j <= k1;
                  if (i == n_m1) begin
                     prev <= m[k][k];
                     k    <= k1;
                  end else begin
                     i <= i + ix_t'(1);
                  end
               end else begin
                  j <= j + ix_t'(1);
               end
            end
            S_FINISH: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               bus.det  <= det_nx;
               bus.ovf  <= rx_ovf;
               bus.err  <= !n_ok;
            end
            default: ;
         endcase
      end
   end
endmodule
